// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stall/flush/bubble decisions for the 5-stage datapath.
// Optional stall-cycle counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_W  = 4,
    parameter int MC_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             df_valid,
    input  logic [REG_W-1:0] df_rs1,
    input  logic [REG_W-1:0] df_rs2,
    input  logic             df_halt,
    input  logic             ex_valid,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_br_taken,
    input  logic             ex_mc_start,
    input  logic             exc_in,
    input  logic             resume,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             if_df_we,
    output logic             if_df_flush,
    output logic             df_ex_nop,
    output logic             ex_hold,
    output logic [1:0]       state,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MC_WAIT = 2'b01,
        ST_HALT    = 2'b10
    } state_t;

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_EXC = 2'b10;
    localparam logic [3:0] MC_LOAD = 4'(MC_LAT - 2);

    state_t     state_q, state_d;
    logic [3:0] mc_cnt_q, mc_cnt_d;
    logic       load_use;
    logic       br_hit;
    logic       mc_hit;
    logic       halt_hit;

    assign load_use = ex_valid & ex_mem_read & df_valid & (ex_rd != '0) &
                      ((ex_rd == df_rs1) | (ex_rd == df_rs2));
    assign br_hit   = ex_valid & ex_br_taken;
    assign mc_hit   = ex_valid & ex_mc_start;
    assign halt_hit = df_valid & df_halt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (exc_in || br_hit) begin
                    state_d = ST_RUN;
                end else if (mc_hit) begin
                    state_d  = ST_MC_WAIT;
                    mc_cnt_d = MC_LOAD;
                end else if (load_use) begin
                    state_d = ST_RUN;
                end else if (halt_hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_MC_WAIT: begin
                if (exc_in) begin
                    state_d  = ST_RUN;
                    mc_cnt_d = '0;
                end else if (mc_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    mc_cnt_d = mc_cnt_q - 4'd1;
                end
            end
            ST_HALT: begin
                if (exc_in || resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d  = ST_RUN;
                mc_cnt_d = '0;
            end
        endcase
    end

    // Outputs are forced low for the whole reset window, not just at the edge.
    always_comb begin
        pc_we       = 1'b0;
        pc_sel      = SEL_SEQ;
        if_df_we    = 1'b0;
        if_df_flush = 1'b0;
        df_ex_nop   = 1'b0;
        ex_hold     = 1'b0;
        if (rst) begin
            unique case (state_q)
                ST_RUN: begin
                    pc_we    = 1'b1;
                    if_df_we = 1'b1;
                    if (exc_in) begin
                        pc_sel      = SEL_EXC;
                        if_df_flush = 1'b1;
                        df_ex_nop   = 1'b1;
                    end else if (br_hit) begin
                        pc_sel      = SEL_BR;
                        if_df_flush = 1'b1;
                        df_ex_nop   = 1'b1;
                    end else if (mc_hit) begin
                        pc_we    = 1'b0;
                        if_df_we = 1'b0;
                        ex_hold  = 1'b1;
                    end else if (load_use || halt_hit) begin
                        pc_we     = 1'b0;
                        if_df_we  = 1'b0;
                        df_ex_nop = 1'b1;
                    end
                end
                ST_MC_WAIT: begin
                    if (exc_in) begin
                        pc_we       = 1'b1;
                        if_df_we    = 1'b1;
                        pc_sel      = SEL_EXC;
                        if_df_flush = 1'b1;
                        df_ex_nop   = 1'b1;
                    end else begin
                        ex_hold = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (exc_in) begin
                        pc_we       = 1'b1;
                        if_df_we    = 1'b1;
                        pc_sel      = SEL_EXC;
                        if_df_flush = 1'b1;
                        df_ex_nop   = 1'b1;
                    end else begin
                        df_ex_nop = 1'b1;
                    end
                end
                default: begin
                    pc_we = 1'b0;
                end
            endcase
        end
    end

    assign state = rst ? state_q : ST_RUN;

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (!pc_we && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
